// File: rtl/spi_pkg.sv
// Shared types for the SPI requester arbiter: FSM state encoding and SPI field widths.
// Pure declarations; no logic, no latency, no flow control.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_MODE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DONE,
    ST_GAP
  } arb_state_e;

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Requester-side and spim-side signals of the SPI arbiter, grouped as one bundle.
// slave = arbiter view; master = the surrounding system (requesters plus spim).
interface spi_req_arbiter_if import spi_pkg::*; #(parameter int NREQ = 4);

  logic [NREQ-1:0]            req;
  logic [SPI_MODE_W*NREQ-1:0] req_mode;
  logic [SPI_DATA_W*NREQ-1:0] req_txdata;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            done;
  logic                       err;
  logic [SPI_DATA_W-1:0]      rxdata;
  logic                       busy;
  logic [NREQ-1:0]            dev_sel;
  logic                       m_start;
  logic [SPI_MODE_W-1:0]      m_mode;
  logic [SPI_DATA_W-1:0]      m_txdata;
  logic [SPI_DATA_W-1:0]      m_rxdata;
  logic                       m_finish;

  modport slave (
    input  req, req_mode, req_txdata, m_rxdata, m_finish,
    output gnt, done, err, rxdata, busy, dev_sel, m_start, m_mode, m_txdata
  );

  modport master (
    output req, req_mode, req_txdata, m_rxdata, m_finish,
    input  gnt, done, err, rxdata, busy, dev_sel, m_start, m_mode, m_txdata
  );

endinterface

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to act on the pick.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        any                            = 1'b1;
        idx                            = PW'((int'(ptr) + i) % NREQ);
        onehot[(int'(ptr) + i) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one spim master among NREQ requesters, one byte per grant, with a watchdog.
// m_start one cycle after req is seen in IDLE; requesters hold req until done, no other backpressure.
module spi_req_arbiter import spi_pkg::*; #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 2
) (
  input logic               clk,
  input logic               rst,
  spi_req_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_e            state_q, state_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [PW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic [SPI_DATA_W-1:0] rxdata_q, rxdata_d;
  logic [SPI_MODE_W-1:0] mode_q, mode_d;
  logic [SPI_DATA_W-1:0] txdata_q, txdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  fin_q, fin_d;

  logic [NREQ-1:0]       pick_onehot;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  fin_rise;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // The edge register samples every cycle, so a level left high from a previous frame never looks new.
  assign fin_rise = bus.m_finish & ~fin_q;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    rxdata_d = rxdata_q;
    mode_d   = mode_q;
    txdata_d = txdata_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    fin_d    = bus.m_finish;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d    = pick_onehot;
          idx_d    = pick_idx;
          mode_d   = bus.req_mode[int'(pick_idx)*SPI_MODE_W +: SPI_MODE_W];
          txdata_d = bus.req_txdata[int'(pick_idx)*SPI_DATA_W +: SPI_DATA_W];
          state_d  = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        // Finish is checked first so it wins a same-cycle collision with the watchdog.
        if (fin_rise) begin
          rxdata_d = bus.m_rxdata;
          err_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rxdata_d = '0;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        err_d   = 1'b0;
        gap_d   = '0;
        ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
      rxdata_q <= '0;
      mode_q   <= '0;
      txdata_q <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      rxdata_q <= rxdata_d;
      mode_q   <= mode_d;
      txdata_q <= txdata_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      fin_q    <= fin_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.dev_sel  = gnt_q;
  assign bus.done     = (state_q == ST_DONE) ? gnt_q : '0;
  assign bus.err      = err_q;
  assign bus.rxdata   = rxdata_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.m_start  = (state_q == ST_START);
  assign bus.m_mode   = mode_q;
  assign bus.m_txdata = txdata_q;

endmodule
